hazard_scoreboard_ctrl: RTL and testbench

Interlock controller for the 5-stage pipeline (fetch, decode, execute, mem, writeback).
- Tracks in-flight register writes with a per-register pending counter.
- Drives the stall into fetch/decode and a bubble into the ID/EX register, so read-after-write hazards never read stale register-file values.
- Provides a flush/drain sequence that stops issue until the pipeline has retired all pending writes.

---
 rtl/hazard_scoreboard_ctrl.sv | 132 +++++++++++++
 tb/tb_hazard_scoreboard_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_scoreboard_ctrl
// Description : RAW interlock scoreboard with per-register pending counters,
//               stall/bubble generation and a flush/drain sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_scoreboard_ctrl #(
    parameter int NUM_REGS = 4,
    parameter int REG_W    = 2,
    parameter int CNT_W    = 3,
    parameter int PERF_W   = 16
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                i_id_valid,
    input  logic                i_id_use_src0,
    input  logic                i_id_use_src1,
    input  logic [REG_W-1:0]    i_id_src0,
    input  logic [REG_W-1:0]    i_id_src1,
    input  logic                i_id_writes,
    input  logic [REG_W-1:0]    i_id_dst,
    input  logic                i_wb_we,
    input  logic [REG_W-1:0]    i_wb_dst,
    input  logic                i_flush_req,
    output logic                o_stall,
    output logic                o_bubble,
    output logic                o_busy,
    output logic [NUM_REGS-1:0] o_pending_mask,
    output logic                o_drained,
    output logic                o_err_underflow,
    output logic [PERF_W-1:0]   o_stall_cycles
);

    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                w_drain_done;
    logic [CNT_W-1:0]    r_cnt [NUM_REGS];
    logic [NUM_REGS-1:0] w_underflow;
    logic                w_all_zero;
    logic                w_hazard;
    logic                w_issue;
    logic                r_drained;
    logic                r_err_underflow;
    logic [PERF_W-1:0]   r_stall_cycles;

    // Hazard terms look only at counters registered at the start of the cycle,
    // so a same-cycle retire never releases the stall early.
    assign w_hazard = i_id_valid &
                      ((i_id_use_src0 & (r_cnt[i_id_src0] != '0)) |
                       (i_id_use_src1 & (r_cnt[i_id_src1] != '0)) |
                       (i_id_writes   & (r_cnt[i_id_dst]  == C_CNT_MAX)));

    assign o_stall        = w_hazard | (r_state == ST_DRAIN);
    assign o_bubble       = o_stall & i_id_valid;
    assign w_issue        = i_id_valid & ~o_stall;
    assign w_all_zero     = ~|o_pending_mask;
    assign o_busy         = |o_pending_mask;
    assign o_drained      = r_drained;
    assign o_err_underflow = r_err_underflow;
    assign o_stall_cycles = r_stall_cycles;

    generate
        for (genvar g = 0; g < NUM_REGS; g++) begin : g_cnt
            logic w_inc;
            logic w_dec;

            assign w_inc             = w_issue & i_id_writes & (i_id_dst == REG_W'(g));
            assign w_dec             = i_wb_we & (i_wb_dst == REG_W'(g));
            assign w_underflow[g]    = w_dec & ~w_inc & (r_cnt[g] == '0);
            assign o_pending_mask[g] = |r_cnt[g];

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    r_cnt[g] <= '0;
                end else if (w_inc && !w_dec) begin
                    r_cnt[g] <= r_cnt[g] + CNT_W'(1);
                end else if (w_dec && !w_inc && (r_cnt[g] != '0)) begin
                    r_cnt[g] <= r_cnt[g] - CNT_W'(1);
                end
            end
        end
    endgenerate

    always_comb begin
        w_state_nxt  = r_state;
        w_drain_done = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (i_flush_req) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_all_zero) begin
                    w_state_nxt  = ST_RUN;
                    w_drain_done = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state         <= ST_RUN;
            r_drained       <= 1'b0;
            r_err_underflow <= 1'b0;
            r_stall_cycles  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_drained <= w_drain_done;
            if (|w_underflow) begin
                r_err_underflow <= 1'b1;
            end
            if (o_stall && (r_stall_cycles != '1)) begin
                r_stall_cycles <= r_stall_cycles + PERF_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_scoreboard_ctrl
// Description : Vector table, directed corner sequences and randomized
//               traffic against a counting reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_scoreboard_ctrl;

    localparam int NUM_REGS = 4;
    localparam int REG_W    = 2;
    localparam int CNT_W    = 3;
    localparam int PERF_W   = 16;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;
    localparam int PERF_MAX = (1 << PERF_W) - 1;

    logic                clk = 1'b0;
    logic                resetn = 1'b1;
    logic                id_valid, id_use_src0, id_use_src1, id_writes;
    logic [REG_W-1:0]    id_src0, id_src1, id_dst, wb_dst;
    logic                wb_we, flush_req;
    logic                stall, bubble, busy, drained, err_underflow;
    logic [NUM_REGS-1:0] pending_mask;
    logic [PERF_W-1:0]   stall_cycles;

    int checks   = 0;
    int failures = 0;

    int m_cnt [NUM_REGS];
    bit m_drain, m_err, m_drained;
    int m_perf;

    hazard_scoreboard_ctrl #(
        .NUM_REGS(NUM_REGS), .REG_W(REG_W), .CNT_W(CNT_W), .PERF_W(PERF_W)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .i_id_valid     (id_valid),
        .i_id_use_src0  (id_use_src0),
        .i_id_use_src1  (id_use_src1),
        .i_id_src0      (id_src0),
        .i_id_src1      (id_src1),
        .i_id_writes    (id_writes),
        .i_id_dst       (id_dst),
        .i_wb_we        (wb_we),
        .i_wb_dst       (wb_dst),
        .i_flush_req    (flush_req),
        .o_stall        (stall),
        .o_bubble       (bubble),
        .o_busy         (busy),
        .o_pending_mask (pending_mask),
        .o_drained      (drained),
        .o_err_underflow(err_underflow),
        .o_stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic v, u0, u1; logic [1:0] s0, s1; logic w; logic [1:0] d;
        logic we; logic [1:0] wd; logic fl;
        logic e_stall, e_bubble; logic [3:0] e_mask; logic e_drained, e_err; int e_perf;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_hazard();
        if (!id_valid) return 1'b0;
        return (id_use_src0 && m_cnt[id_src0] != 0) ||
               (id_use_src1 && m_cnt[id_src1] != 0) ||
               (id_writes && m_cnt[id_dst] == CNT_MAX);
    endfunction

    function automatic bit m_stall();
        return m_hazard() || m_drain;
    endfunction

    function automatic logic [NUM_REGS-1:0] m_mask();
        logic [NUM_REGS-1:0] m;
        for (int i = 0; i < NUM_REGS; i++) m[i] = (m_cnt[i] != 0);
        return m;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < NUM_REGS; i++) m_cnt[i] = 0;
        m_drain = 0; m_err = 0; m_drained = 0; m_perf = 0;
    endtask

    task automatic model_check();
        chk("m_stall",   32'(stall),         32'(m_stall()));
        chk("m_bubble",  32'(bubble),        32'(m_stall() && id_valid));
        chk("m_busy",    32'(busy),          32'(m_mask() != '0));
        chk("m_mask",    32'(pending_mask),  32'(m_mask()));
        chk("m_drained", 32'(drained),       32'(m_drained));
        chk("m_err",     32'(err_underflow), 32'(m_err));
        chk("m_perf",    32'(stall_cycles),  32'(m_perf));
    endtask

    task automatic model_update();
        bit st, all0, issue;
        st    = m_stall();
        all0  = (m_mask() == '0);
        issue = id_valid && !st;
        m_drained = m_drain && all0;
        if (st && m_perf < PERF_MAX) m_perf++;
        if (issue && id_writes) m_cnt[id_dst]++;
        if (wb_we) begin
            if (m_cnt[wb_dst] > 0) m_cnt[wb_dst]--;
            else m_err = 1;
        end
        m_drain = m_drain ? !all0 : flush_req;
    endtask

    task automatic at_neg(); @(negedge clk); model_check(); endtask
    task automatic at_pos(); @(posedge clk); model_update(); #1; endtask
    task automatic step(); at_neg(); at_pos(); endtask

    task automatic idle();
        id_valid = 0; id_use_src0 = 0; id_use_src1 = 0; id_src0 = 0; id_src1 = 0;
        id_writes = 0; id_dst = 0; wb_we = 0; wb_dst = 0; flush_req = 0;
    endtask

    // Asynchronous reset: outputs must reach reset values without a clock edge.
    task automatic do_reset();
        idle();
        resetn = 0;
        #1;
        chk("rst_stall",   32'(stall), 0);
        chk("rst_bubble",  32'(bubble), 0);
        chk("rst_busy",    32'(busy), 0);
        chk("rst_mask",    32'(pending_mask), 0);
        chk("rst_drained", 32'(drained), 0);
        chk("rst_err",     32'(err_underflow), 0);
        chk("rst_perf",    32'(stall_cycles), 0);
        @(posedge clk); #1;
        resetn = 1;
        m_reset();
    endtask

    vec_t tbl [14];

    initial begin
        tbl[0]  = '{1,0,0,0,0,1,1,0,0,0, 0,0,4'b0000,0,0,0};
        tbl[1]  = '{1,1,0,1,0,0,0,0,0,0, 1,1,4'b0010,0,0,0};
        tbl[2]  = '{1,1,0,1,0,0,0,0,0,0, 1,1,4'b0010,0,0,1};
        tbl[3]  = '{1,1,0,1,0,0,0,1,1,0, 1,1,4'b0010,0,0,2};
        tbl[4]  = '{1,1,0,1,0,0,0,0,0,0, 0,0,4'b0000,0,0,3};
        tbl[5]  = '{1,0,0,0,0,1,0,0,0,0, 0,0,4'b0000,0,0,3};
        tbl[6]  = '{1,0,0,0,0,1,0,1,0,0, 0,0,4'b0001,0,0,3};
        tbl[7]  = '{0,0,0,0,0,0,0,0,0,0, 0,0,4'b0001,0,0,3};
        tbl[8]  = '{0,0,0,0,0,0,0,1,0,0, 0,0,4'b0001,0,0,3};
        tbl[9]  = '{0,0,0,0,0,0,0,1,3,0, 0,0,4'b0000,0,0,3};
        tbl[10] = '{0,0,0,0,0,0,0,0,0,0, 0,0,4'b0000,0,1,3};
        tbl[11] = '{0,0,0,0,0,0,0,0,0,1, 0,0,4'b0000,0,1,3};
        tbl[12] = '{1,0,0,0,0,0,0,0,0,0, 1,1,4'b0000,0,1,3};
        tbl[13] = '{1,0,0,0,0,0,0,0,0,0, 0,0,4'b0000,1,1,4};

        idle();
        m_reset();
        #2;
        do_reset();

        for (int i = 0; i < 14; i++) begin
            id_valid = tbl[i].v; id_use_src0 = tbl[i].u0; id_use_src1 = tbl[i].u1;
            id_src0 = tbl[i].s0; id_src1 = tbl[i].s1; id_writes = tbl[i].w;
            id_dst = tbl[i].d; wb_we = tbl[i].we; wb_dst = tbl[i].wd; flush_req = tbl[i].fl;
            at_neg();
            chk($sformatf("tbl%0d_stall", i),   32'(stall),         32'(tbl[i].e_stall));
            chk($sformatf("tbl%0d_bubble", i),  32'(bubble),        32'(tbl[i].e_bubble));
            chk($sformatf("tbl%0d_mask", i),    32'(pending_mask),  32'(tbl[i].e_mask));
            chk($sformatf("tbl%0d_drained", i), 32'(drained),       32'(tbl[i].e_drained));
            chk($sformatf("tbl%0d_err", i),     32'(err_underflow), 32'(tbl[i].e_err));
            chk($sformatf("tbl%0d_perf", i),    32'(stall_cycles),  32'(tbl[i].e_perf));
            at_pos();
        end

        // Fill R2 to the counter ceiling; the next writer must wait for a retire.
        do_reset();
        for (int i = 0; i < CNT_MAX; i++) begin
            idle(); id_valid = 1; id_writes = 1; id_dst = 2;
            step();
        end
        wb_we = 1; wb_dst = 2;
        at_neg();
        chk("cntmax_stall", 32'(stall), 1);
        at_pos();
        wb_we = 0;
        at_neg();
        chk("cntmax_release", 32'(stall), 0);
        at_pos();
        at_neg();
        chk("cntmax_refull", 32'(stall), 1);
        at_pos();

        // Drain with two outstanding writes to R1.
        do_reset();
        idle(); id_valid = 1; id_writes = 1; id_dst = 1;
        step(); step();
        idle(); flush_req = 1;
        at_neg();
        chk("drain_req_stall", 32'(stall), 0);
        at_pos();
        for (int c = 1; c <= 5; c++) begin
            idle();
            if (c == 2 || c == 4) begin wb_we = 1; wb_dst = 1; end
            if (c == 3) begin id_valid = 1; id_writes = 1; id_dst = 0; flush_req = 1; end
            at_neg();
            chk($sformatf("drain_c%0d_stall", c), 32'(stall), 1);
            chk($sformatf("drain_c%0d_drained", c), 32'(drained), 0);
            if (c == 4) chk("drain_block_issue", 32'(pending_mask), 32'(4'b0010));
            at_pos();
        end
        idle(); id_valid = 1;
        at_neg();
        chk("drain_pulse", 32'(drained), 1);
        chk("drain_exit_stall", 32'(stall), 0);
        at_pos();
        at_neg();
        chk("drain_pulse_end", 32'(drained), 0);
        at_pos();

        // Underflow is sticky; a reset in the middle of a drain clears everything.
        do_reset();
        idle(); wb_we = 1; wb_dst = 3;
        step();
        idle();
        for (int c = 0; c < 3; c++) begin
            at_neg();
            chk($sformatf("uf_err%0d", c), 32'(err_underflow), 1);
            chk($sformatf("uf_cnt3_%0d", c), 32'(pending_mask[3]), 0);
            at_pos();
        end
        id_valid = 1; id_writes = 1; id_dst = 3;
        step();
        idle(); flush_req = 1;
        step();
        idle();
        at_neg();
        chk("middrain_stall", 32'(stall), 1);
        do_reset();
        idle(); id_valid = 1;
        at_neg();
        chk("post_rst_run", 32'(stall), 0);
        at_pos();

        // Randomized traffic with retires biased toward pending registers.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            int r;
            idle();
            id_valid    = ($urandom % 4) != 0;
            id_use_src0 = $urandom % 2;
            id_use_src1 = $urandom % 2;
            id_src0     = REG_W'($urandom);
            id_src1     = REG_W'($urandom);
            id_writes   = ($urandom % 3) != 0;
            id_dst      = REG_W'($urandom);
            flush_req   = ($urandom % 40) == 0;
            r = int'($urandom % NUM_REGS);
            if ($urandom % 10 != 0) begin
                for (int k = 0; k < NUM_REGS; k++) begin
                    if (!wb_we && m_cnt[(r + k) % NUM_REGS] != 0) begin
                        wb_we  = ($urandom % 3) != 0;
                        wb_dst = REG_W'((r + k) % NUM_REGS);
                    end
                end
            end else begin
                wb_we  = 1;
                wb_dst = REG_W'(r);
            end
            step();
            if (n % 1000 == 999) do_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
